// File: rtl/clock_period_meter.sv
// Measures the half-period of a slow asynchronous square wave in boardCLK cycles
// and reports it as a divider value, with lock and loss-of-signal indication.
module clock_period_meter #(
   parameter logic [31:0] TIMEOUT = 32'd50_000_000,
   parameter logic [31:0] TOL     = 32'd1
) (
   input  logic        boardCLK,
   input  logic        boardRST_n,
   input  logic        clk_in,
   output logic [31:0] divider_out,
   output logic        valid,
   output logic        locked,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        s1;
   logic        s2;
   logic        s3;
   logic        edge_seen;

   logic [31:0] cnt;
   logic [31:0] hprev;
   logic        hprev_vld;
   logic [31:0] diff;
   logic        match;
   logic        cnt_at_limit;

   always_ff @(posedge boardCLK) begin
      if (!boardRST_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= clk_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Both transitions of clk_in count, so each measurement is a half-period.
   assign edge_seen    = s2 ^ s3;
   assign cnt_at_limit = (cnt == TIMEOUT);

   always_comb begin
      diff = '0;
      if (cnt >= hprev) begin
         diff = cnt - hprev;
      end else begin
         diff = hprev - cnt;
      end
   end

   assign match = hprev_vld && (diff <= TOL);

   always_ff @(posedge boardCLK) begin
      if (!boardRST_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (edge_seen) begin
               state_nxt = MEASURE;
            end
         end
         MEASURE, LOCKED: begin
            if (edge_seen) begin
               state_nxt = match ? LOCKED : MEASURE;
            end else if (cnt_at_limit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An edge coinciding with cnt == TIMEOUT is a valid measurement, not a loss.
   always_ff @(posedge boardCLK) begin
      if (!boardRST_n) begin
         cnt         <= '0;
         hprev       <= '0;
         hprev_vld   <= 1'b0;
         divider_out <= '0;
         valid       <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (edge_seen) begin
                  cnt     <= 32'd1;
                  timeout <= 1'b0;
               end
            end
            default: begin
               if (edge_seen) begin
                  divider_out <= cnt - 32'd1;
                  valid       <= 1'b1;
                  hprev       <= cnt;
                  hprev_vld   <= 1'b1;
                  cnt         <= 32'd1;
               end else if (cnt_at_limit) begin
                  timeout   <= 1'b1;
                  hprev_vld <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
         endcase
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32'd50_000_000: max boardCLK cycles between clk_in edges before loss of signal (1 s at 50 MHz); legal range 2..2^32-1.
REQ-002 SHALL have parameter TOL, default 32'd1: max unsigned difference between consecutive half-periods still counted as matching.
REQ-003 SHALL have port boardCLK, input, 1 bit: single system clock (50 MHz board clock); all logic on its rising edge.
REQ-004 SHALL have port boardRST_n, input, 1 bit: reset, synchronous to boardCLK, active-low.
REQ-005 SHALL have port clk_in, input, 1 bit: measured slow square wave, asynchronous to boardCLK.
REQ-006 SHALL have port divider_out, output, 32 bits: latest measured divider value, encoded so that feeding it back to the team's clock divider reproduces clk_in.
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse when divider_out is updated.
REQ-008 SHALL have port locked, output, 1 bit: level, high while consecutive measurements match within TOL.
REQ-009 SHALL have port timeout, output, 1 bit: sticky level, high after loss of clk_in.

Function
REQ-010 SHALL pass clk_in through a 2-flop synchronizer (s1, s2), then a third flop s3; edge = (s2 != s3), so both rising and falling edges count.
REQ-011 SHALL implement states IDLE, MEASURE, LOCKED.
REQ-012 IDLE: on edge, SHALL load counter cnt = 1 and go to MEASURE; SHALL NOT pulse valid.
REQ-013 MEASURE/LOCKED, no edge: SHALL increment cnt by 1 each cycle.
REQ-014 MEASURE/LOCKED, edge: SHALL capture H = cnt, set divider_out = H - 1 (32-bit unsigned), pulse valid high for exactly that next cycle, store H as Hprev, and reload cnt = 1.
REQ-015 Spacing: clk_in toggling every N boardCLK cycles SHALL yield H = N and divider_out = N - 1 in steady state; valid SHALL be registered one cycle after the edge-detect cycle.
REQ-016 Match: |H - Hprev| <= TOL, with Hprev valid (at least one prior measurement since IDLE), SHALL move state to or stay in LOCKED and set locked = 1.
REQ-017 Mismatch, or no valid Hprev: state SHALL be MEASURE and locked = 0.
REQ-018 Difference SHALL be computed unsigned as larger minus smaller; no wrap-around.
REQ-019 In MEASURE/LOCKED, cnt == TIMEOUT with no edge SHALL go to IDLE, set timeout = 1, clear locked, and invalidate Hprev. divider_out SHALL hold; valid SHALL stay 0.
REQ-020 cnt SHALL never exceed TIMEOUT; no other saturation logic is required.
REQ-021 Edge in the same cycle as cnt == TIMEOUT: the edge SHALL win (REQ-014 applies, no timeout).
REQ-022 timeout SHALL clear on the first edge detected in IDLE.
REQ-023 H = 1 (edges on consecutive cycles) SHALL report divider_out = 0 with no special handling.

Reset
REQ-024 While boardRST_n = 0 at a boardCLK rising edge, the block SHALL clear s1, s2, s3, cnt, Hprev and its valid flag, divider_out, valid, locked and timeout, and set state to IDLE.
REQ-025 Reset SHALL override every other event in that cycle, including edge and timeout.
REQ-026 A spurious edge after reset release (clk_in already high) SHALL only start a measurement, per REQ-012.

Verification
REQ-027 clk_in toggles every 25 cycles -> no valid on first edge; valid pulse from second edge on with divider_out = 24; locked = 1 from third edge.
REQ-028 Spacing 25, 26, 25, then 40 (TOL = 1) -> locked stays 1 through 26/25; at the 40 edge divider_out = 39, locked = 0, state MEASURE; next 40 -> locked = 1.
REQ-029 TIMEOUT = 100, toggling stops -> 100 cycles after last edge timeout = 1, locked = 0, divider_out held; next edge clears timeout with no valid; following edge gives valid.
REQ-030 TIMEOUT = 100, edge exactly at cnt == 100 -> valid with divider_out = 99, timeout stays 0.
REQ-031 boardRST_n low for 1 cycle mid-measurement while locked -> all outputs 0 the next cycle; first edge after release gives no valid; second edge gives a correct measurement.
REQ-032 Random clk_in spacing 1..200 vs reference model -> every valid matches H - 1 exactly; locked matches the model's TOL rule every cycle.
